// File: rtl/rtc_timekeeper_if.sv
// Bus bundle for rtc_timekeeper: time load, alarm setup and time/flag outputs.
// The timekeeper is the slave; the controlling logic is the master.
interface rtc_timekeeper_if;
    logic       load;
    logic [4:0] load_hh;
    logic [5:0] load_mm;
    logic [5:0] load_ss;
    logic       mode12;
    logic       alarm_wr;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic       alarm_en;
    logic       alarm_ack;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic       sec_tick;
    logic       day_tick;
    logic       load_err;
    logic       alarm_irq;

    modport slave (
        input  load, load_hh, load_mm, load_ss, mode12,
        input  alarm_wr, alarm_hh, alarm_mm, alarm_en, alarm_ack,
        output seconds, minutes, hours, pm,
        output sec_tick, day_tick, load_err, alarm_irq
    );

    modport master (
        output load, load_hh, load_mm, load_ss, mode12,
        output alarm_wr, alarm_hh, alarm_mm, alarm_en, alarm_ack,
        input  seconds, minutes, hours, pm,
        input  sec_tick, day_tick, load_err, alarm_irq
    );
endinterface

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter with prescaler, 12/24 h display, checked load,
// day-rollover strobe and sticky hh:mm alarm.
module rtc_timekeeper #(
    parameter int TICK_DIV = 100
) (
    input  logic               clk,
    input  logic               reset,
    rtc_timekeeper_if.slave    bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [4:0]    r_hh;
    logic [5:0]    r_mm;
    logic [5:0]    r_ss;
    logic [4:0]    r_al_hh;
    logic [5:0]    r_al_mm;
    logic          r_irq;
    logic          r_sec_tick;
    logic          r_day_tick;
    logic          r_load_err;

    logic          w_tick;
    logic          w_load_ok;
    logic          w_load_bad;
    logic [4:0]    w_hh_nx;
    logic [5:0]    w_mm_nx;
    logic [5:0]    w_ss_nx;
    logic          w_day;
    logic          w_fire;
    logic [4:0]    w_hh12;

    assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
    assign w_load_ok  = bus.load && (bus.load_hh <= 5'd23) &&
                        (bus.load_mm <= 6'd59) && (bus.load_ss <= 6'd59);
    assign w_load_bad = bus.load && !w_load_ok;

    always_comb begin
        w_ss_nx = r_ss + 6'd1;
        w_mm_nx = r_mm;
        w_hh_nx = r_hh;
        w_day   = 1'b0;
        if (r_ss == 6'd59) begin
            w_ss_nx = 6'd0;
            if (r_mm == 6'd59) begin
                w_mm_nx = 6'd0;
                if (r_hh == 5'd23) begin
                    w_hh_nx = 5'd0;
                    w_day   = 1'b1;
                end else begin
                    w_hh_nx = r_hh + 5'd1;
                end
            end else begin
                w_mm_nx = r_mm + 6'd1;
            end
        end
    end

    // Compare against the pre-edge alarm registers so a same-cycle write
    // does not affect the current match.
    assign w_fire = w_tick && !w_load_ok && bus.alarm_en &&
                    (w_hh_nx == r_al_hh) && (w_mm_nx == r_al_mm) &&
                    (w_ss_nx == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_hh       <= '0;
            r_mm       <= '0;
            r_ss       <= '0;
            r_al_hh    <= '0;
            r_al_mm    <= '0;
            r_irq      <= 1'b0;
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_tick <= 1'b0;
            r_load_err <= w_load_bad;
            if (bus.alarm_wr) begin
                r_al_hh <= bus.alarm_hh;
                r_al_mm <= bus.alarm_mm;
            end
            if (w_load_ok) begin
                r_hh    <= bus.load_hh;
                r_mm    <= bus.load_mm;
                r_ss    <= bus.load_ss;
                r_presc <= '0;
            end else if (w_tick) begin
                r_presc    <= '0;
                r_hh       <= w_hh_nx;
                r_mm       <= w_mm_nx;
                r_ss       <= w_ss_nx;
                r_sec_tick <= 1'b1;
                r_day_tick <= w_day;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (w_fire) begin
                r_irq <= 1'b1;
            end else if (bus.alarm_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    always_comb begin
        w_hh12 = r_hh;
        if (r_hh == 5'd0) begin
            w_hh12 = 5'd12;
        end else if (r_hh > 5'd12) begin
            w_hh12 = r_hh - 5'd12;
        end
    end

    assign bus.seconds   = r_ss;
    assign bus.minutes   = r_mm;
    assign bus.hours     = bus.mode12 ? w_hh12 : r_hh;
    assign bus.pm        = (r_hh >= 5'd12);
    assign bus.sec_tick  = r_sec_tick;
    assign bus.day_tick  = r_day_tick;
    assign bus.load_err  = r_load_err;
    assign bus.alarm_irq = r_irq;
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised time-of-day counter that extends the free-running minutes/seconds counter with an internal clock prescaler, hours, 12/24-hour display mode, synchronous time load with range checking, a day-rollover pulse and a sticky hh:mm alarm. It sits between the system clock domain and the display/interrupt logic. It is the time base for any block that needs wall-clock time or a 1 Hz strobe.

## Interface
- TICK_DIV, default 100: clk cycles per second; legal range ≥1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  load time from load_hh/load_mm/load_ss this cycle.
- load_hh  in  5  hours to load, 0..23.
- load_mm  in  6  minutes to load, 0..59.
- load_ss  in  6  seconds to load, 0..59.
- mode12  in  1  display mode: 0 = 24 h, 1 = 12 h.
- alarm_wr  in  1  capture alarm_hh/alarm_mm into the alarm registers.
- alarm_hh  in  5  alarm hour, 0..23 (always 24 h).
- alarm_mm  in  6  alarm minute, 0..59.
- alarm_en  in  1  alarm compare enable.
- alarm_ack  in  1  clears alarm_irq.
- seconds  out  6  current seconds, 0..59.
- minutes  out  6  current minutes, 0..59.
- hours  out  5  displayed hour: 0..23 (mode12=0) or 1..12 (mode12=1).
- pm  out  1  internal hour ≥12, valid in both modes.
- sec_tick  out  1  one-cycle pulse, the cycle the new time is first visible.
- day_tick  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- load_err  out  1  one-cycle pulse, load rejected.
- alarm_irq  out  1  sticky alarm flag.

## Operation
- Internal state: presc (width $clog2(TICK_DIV), minimum 1 bit), hh24 (0..23), mm, ss, alarm registers, alarm_irq.
- Reset: presc, hh24, mm, ss, alarm registers = 0. alarm_irq, sec_tick, day_tick, load_err = 0. Outputs: seconds = minutes = 0, pm = 0. hours = 0 (24 h) or 12 (12 h).
- Tick condition T = (presc == TICK_DIV-1). On T, presc ← 0; otherwise presc ← presc+1. With TICK_DIV=1, T is true every cycle.
- Advance on T: ss increments. At 59 it wraps to 0 and carries into mm. mm at 59 wraps to 0 and carries into hh24. hh24 at 23 wraps to 0. Arithmetic stays within the field widths; no value outside the legal range is ever stored.
- Load, highest priority after reset. When load=1 and all fields are in range, the time is replaced with the load values and presc ← 0. No advance occurs that cycle, and no sec_tick, day_tick or alarm is generated by it.
- Rejected load: when load=1 and any field is out of range (hh>23, mm>59, ss>59), time and presc are unchanged, load_err pulses, and the normal tick still proceeds.
- 12 h mapping (combinational from hh24): 0 → 12, 1..12 → same, 13..23 → hh24-12. pm = (hh24 ≥ 12). mode12 changes only the display and may toggle at any time.
- Alarm registers are updated on alarm_wr, independent of load and tick.
- Alarm fires when an advance (not a load) produces hh24 == alarm_hh, mm == alarm_mm and ss == 0 while alarm_en = 1. It then sets alarm_irq.
- alarm_irq clears on alarm_ack. If set and ack occur in the same cycle, set wins.
- An alarm_wr coinciding with a matching advance compares against the old alarm registers.

## Timing
- The time registers, sec_tick, day_tick, load_err and alarm_irq are all registered and update on the same edge.
- sec_tick is high for exactly one cycle every TICK_DIV cycles. The first sec_tick after reset or after a load is TICK_DIV cycles after the reset/load edge.
- day_tick coincides with the sec_tick that shows 00:00:00.
- alarm_irq rises on the same edge that shows hh:mm:00.
- Load latency: one cycle; the new time is visible the cycle after load is sampled high.
- Reset mid-operation clears everything on the next edge, regardless of load, alarm_wr or ack.

## Test plan
- TICK_DIV=4: release reset, run 16 cycles → sec_tick pulses on cycles 4, 8, 12, 16 after reset; seconds = 4; hours = 0; pm = 0.
- Load 23:59:58, then 2 ticks → first tick shows 23:59:59. Second tick shows 00:00:00 with day_tick=1 for one cycle; pm goes 1→0.
- mode12 sweep: load 00:00:00, 12:00:00, 13:05:00 → hours/pm = 12/0, 12/1, 1/1. With mode12=0 → 0, 12, 13.
- Load 24:00:00, then 10:60:00 → load_err pulses each time; time and the sec_tick cadence are unchanged.
- Alarm 07:30 with alarm_en=1: load 07:29:59, one tick → 07:30:00 and alarm_irq=1. alarm_irq stays set until alarm_ack. Repeating with ack on the setting edge leaves alarm_irq=1.
- Load 07:30:00 directly → no alarm. Same advance with alarm_en=0 → no alarm. Assert reset during a load → all zero next cycle.
